// File: rtl/apb_initiator_pkg.sv
// Shared types and helpers for the APB initiator bridge.
package apb_initiator_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    // Width of the ACCESS-phase wait counter; at least one bit even when
    // the timeout is disabled.
    function automatic int unsigned cnt_width(input int unsigned timeout_cycles);
        int unsigned w;
        w = $clog2(timeout_cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/apb_bus.sv
// APB3 bus bundle between the bridge and the peripheral bus wrapper.
interface APB_BUS #(
    parameter int unsigned APB_ADDR_WIDTH = 32,
    parameter int unsigned APB_DATA_WIDTH = 32
);
    logic [APB_ADDR_WIDTH-1:0] paddr;
    logic [APB_DATA_WIDTH-1:0] pwdata;
    logic                      pwrite;
    logic                      psel;
    logic                      penable;
    logic [APB_DATA_WIDTH-1:0] prdata;
    logic                      pready;
    logic                      pslverr;

    modport Master (
        output paddr, pwdata, pwrite, psel, penable,
        input  prdata, pready, pslverr
    );

    modport Slave (
        input  paddr, pwdata, pwrite, psel, penable,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_initiator_bridge.sv
// Core request/grant to APB3 initiator, one outstanding transfer, with an
// optional ACCESS-phase timeout for peripherals that never raise PREADY.
module apb_initiator_bridge
    import apb_initiator_pkg::*;
#(
    parameter int unsigned APB_ADDR_WIDTH = 32,
    parameter int unsigned APB_DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      req_i,
    input  logic                      we_i,
    input  logic [APB_ADDR_WIDTH-1:0] addr_i,
    input  logic [APB_DATA_WIDTH-1:0] wdata_i,
    output logic                      gnt_o,
    output logic                      rvalid_o,
    output logic [APB_DATA_WIDTH-1:0] rdata_o,
    output logic                      err_o,
    APB_BUS.Master                    apb_master
);

    localparam int unsigned CW    = cnt_width(TIMEOUT_CYCLES);
    localparam bit          TO_EN = (TIMEOUT_CYCLES != 0);
    // Last counter value before abort; unused when the timeout is disabled.
    localparam logic [CW-1:0] TO_LAST = TO_EN ? CW'(TIMEOUT_CYCLES - 1) : '0;

    state_t                    state;
    logic [CW-1:0]             cnt;
    logic [APB_ADDR_WIDTH-1:0] paddr;
    logic [APB_DATA_WIDTH-1:0] pwdata;
    logic                      pwrite;
    logic                      psel;
    logic                      penable;

    // Grant is only possible while idle; the request is held by the core.
    assign gnt_o = req_i && (state == IDLE);

    assign apb_master.paddr   = paddr;
    assign apb_master.pwdata  = pwdata;
    assign apb_master.pwrite  = pwrite;
    assign apb_master.psel    = psel;
    assign apb_master.penable = penable;

    // Transfer FSM with registered APB drive, wait counter and completion.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= IDLE;
            cnt      <= '0;
            paddr    <= '0;
            pwdata   <= '0;
            pwrite   <= 1'b0;
            psel     <= 1'b0;
            penable  <= 1'b0;
            rvalid_o <= 1'b0;
            err_o    <= 1'b0;
            rdata_o  <= '0;
        end else begin
            rvalid_o <= 1'b0;
            err_o    <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_i) begin
                        paddr   <= addr_i;
                        pwdata  <= wdata_i;
                        pwrite  <= we_i;
                        psel    <= 1'b1;
                        penable <= 1'b0;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    penable <= 1'b1;
                    cnt     <= '0;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    // A ready slave wins over a timeout expiring this cycle.
                    if (apb_master.pready) begin
                        rvalid_o <= 1'b1;
                        err_o    <= apb_master.pslverr;
                        rdata_o  <= pwrite ? '0 : apb_master.prdata;
                        psel     <= 1'b0;
                        penable  <= 1'b0;
                        pwrite   <= 1'b0;
                        state    <= IDLE;
                    end else if (TO_EN && (cnt == TO_LAST)) begin
                        rvalid_o <= 1'b1;
                        err_o    <= 1'b1;
                        rdata_o  <= '0;
                        psel     <= 1'b0;
                        penable  <= 1'b0;
                        pwrite   <= 1'b0;
                        state    <= IDLE;
                    end else if (cnt != '1) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    psel    <= 1'b0;
                    penable <= 1'b0;
                    pwrite  <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_initiator_bridge.sv
// Directed + randomized bench for apb_initiator_bridge with a behavioural
// APB slave and a per-transfer latency/result model.
module tb_apb_initiator_bridge;

    localparam int unsigned T  = 4;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          req = 1'b0;
    logic          we = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] wdata = '0;
    logic          gnt, rvalid, err;
    logic [DW-1:0] rdata;

    logic          pready = 1'b0;
    logic          pslverr = 1'b0;
    logic [DW-1:0] prdata = '0;

    int            n_chk = 0;
    int            n_fail = 0;
    logic [DW-1:0] last_rdata = '0;

    APB_BUS #(.APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW)) apb ();

    assign apb.pready  = pready;
    assign apb.pslverr = pslverr;
    assign apb.prdata  = prdata;

    apb_initiator_bridge #(
        .APB_ADDR_WIDTH(AW),
        .APB_DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_ni),
        .req_i     (req),
        .we_i      (we),
        .addr_i    (addr),
        .wdata_i   (wdata),
        .gnt_o     (gnt),
        .rvalid_o  (rvalid),
        .rdata_o   (rdata),
        .err_o     (err),
        .apb_master(apb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // One transfer, entered at a negedge with the bridge idle; returns at
    // the negedge of the completion cycle. The slave inserts `waits` wait
    // states, so a transfer with waits >= T must time out.
    task automatic xfer(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input int waits, input logic serr, input logic [DW-1:0] pdat,
                        input bit busy_req);
        bit            tmo;
        int            lat, acc_exp, acc_seen;
        logic          exp_err;
        logic [DW-1:0] exp_rd;
        tmo      = (T != 0) && (waits >= int'(T));
        lat      = tmo ? int'(T) + 2 : waits + 3;
        acc_exp  = tmo ? int'(T) : waits + 1;
        exp_err  = tmo ? 1'b1 : serr;
        exp_rd   = (tmo || w) ? '0 : pdat;
        acc_seen = 0;

        req = 1'b1; we = w; addr = a; wdata = d;
        pready = 1'b0; pslverr = 1'b0;
        #1 chk1("gnt", gnt, 1'b1);

        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            chk1("rvalid", rvalid, c == lat);
            if (c < lat) begin
                chk1("psel", apb.psel, 1'b1);
                chk1("penable", apb.penable, c >= 2);
                chk("paddr", apb.paddr, a);
                chk1("pwrite", apb.pwrite, w);
                chk("pwdata", apb.pwdata, d);
                chk1("gnt_busy", gnt, 1'b0);
            end else begin
                chk1("psel_end", apb.psel, 1'b0);
                chk1("penable_end", apb.penable, 1'b0);
                chk1("pwrite_end", apb.pwrite, 1'b0);
                chk("rdata", rdata, exp_rd);
                chk1("err", err, exp_err);
            end
            // Busy-time requests with junk payload must be ignored.
            if (busy_req && c < lat) begin
                req = 1'b1; addr = $urandom; wdata = $urandom; we = ~w;
            end else begin
                req = 1'b0;
            end
            // Behavioural slave: ready after `waits` ACCESS cycles.
            if (apb.psel && apb.penable) begin
                pready  = (acc_seen == waits);
                pslverr = pready & serr;
                prdata  = pready ? pdat : DW'($urandom);
                acc_seen++;
            end else begin
                pready  = 1'b0;
                pslverr = 1'b0;
            end
        end
        chk("access_cycles", 32'(acc_seen), 32'(acc_exp));
        last_rdata = exp_rd;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        chk1("idle_rvalid", rvalid, 1'b0);
        chk1("idle_err", err, 1'b0);
        chk1("idle_psel", apb.psel, 1'b0);
        chk1("idle_pwrite", apb.pwrite, 1'b0);
        chk("idle_rdata_hold", rdata, last_rdata);
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        chk1("rst_gnt", gnt, 1'b0);
        chk1("rst_rvalid", rvalid, 1'b0);
        chk("rst_rdata", rdata, 32'h0);
        chk1("rst_err", err, 1'b0);
        chk1("rst_psel", apb.psel, 1'b0);
        chk1("rst_penable", apb.penable, 1'b0);
        chk1("rst_pwrite", apb.pwrite, 1'b0);
        chk("rst_paddr", apb.paddr, 32'h0);
        chk("rst_pwdata", apb.pwdata, 32'h0);
        @(negedge clk);
        rst_ni = 1'b1;
        idle_cycle();

        // Read, zero wait
        xfer(1'b0, 32'h1A10_0000, 32'h0, 0, 1'b0, 32'hDEAD_BEEF, 1'b0);
        idle_cycle();
        // Write, 3 wait states, with ignored busy requests
        xfer(1'b1, 32'h1A10_0004, 32'h0000_00A5, 3, 1'b0, 32'h1234_5678, 1'b1);
        idle_cycle();
        // Slave error on a read
        xfer(1'b0, 32'h1A10_0008, 32'h0, 1, 1'b1, 32'hCAFE_F00D, 1'b0);
        idle_cycle();
        // Timeout: slave never ready
        xfer(1'b0, 32'h1A10_000C, 32'h0, 100, 1'b0, 32'h5555_AAAA, 1'b0);
        idle_cycle();
        // Back-to-back with req held
        xfer(1'b0, 32'h1A10_0010, 32'h0, 0, 1'b0, 32'h0BAD_CAFE, 1'b1);
        xfer(1'b1, 32'h1A10_0014, 32'h7777_0001, 0, 1'b0, 32'h0, 1'b0);
        idle_cycle();

        // Reset mid-ACCESS
        req = 1'b1; we = 1'b0; addr = 32'h1A10_0040; pready = 1'b0;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        chk1("pre_rst_penable", apb.penable, 1'b1);
        rst_ni = 1'b0;
        #1;
        chk1("arst_psel", apb.psel, 1'b0);
        chk1("arst_penable", apb.penable, 1'b0);
        chk1("arst_rvalid", rvalid, 1'b0);
        chk("arst_rdata", rdata, 32'h0);
        chk1("arst_err", err, 1'b0);
        chk("arst_paddr", apb.paddr, 32'h0);
        @(negedge clk);
        rst_ni = 1'b1;
        last_rdata = '0;
        for (int i = 0; i < 3; i++) idle_cycle();
        xfer(1'b0, 32'h1A10_0044, 32'h0, 2, 1'b0, 32'h0F0F_0F0F, 1'b0);
        idle_cycle();

        // Randomized transfers
        for (int i = 0; i < 40; i++) begin
            logic          rw, se;
            logic [AW-1:0] ra;
            logic [DW-1:0] rd, rp;
            int            wt;
            bit            b2b, busy;
            rw   = 1'($urandom_range(0, 1));
            ra   = AW'($urandom) & ~AW'(3);
            rd   = DW'($urandom);
            rp   = DW'($urandom);
            wt   = int'($urandom_range(0, 6));
            se   = ($urandom_range(0, 3) == 0);
            b2b  = ($urandom_range(0, 1) == 1);
            busy = ($urandom_range(0, 2) == 0);
            xfer(rw, ra, rd, wt, se, rp, busy);
            if (!b2b) idle_cycle();
        end
        idle_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
